// File: rtl/display_ctrl_pkg.sv
// Shared constants, classifier state type and threshold helpers for the
// display/buzzer source scheduler.
package display_ctrl_pkg;

  localparam logic SRC_GSENSOR = 1'b0;
  localparam logic SRC_LIGHT   = 1'b1;

  localparam int ALARM_G_BIT = 0;
  localparam int ALARM_L_BIT = 1;

  localparam int DEF_DWELL_CYCLES      = 100_000_000;
  localparam int DEF_DEBOUNCE_CYCLES   = 1_000_000;
  localparam int DEF_LONG_PRESS_CYCLES = 50_000_000;
  localparam int DEF_G_THRESH          = 2;
  localparam int DEF_L_THRESH          = 5;
  localparam int DEF_ALARM_PERSIST     = 4;

  typedef enum logic [1:0] {
    CLS_IDLE         = 2'd0,
    CLS_PRESSED      = 2'd1,
    CLS_LONG_HELD    = 2'd2,
    CLS_WAIT_RELEASE = 2'd3
  } cls_state_e;

  // Tilt alarm when the signed code is at or beyond +/- thresh.
  function automatic logic g_over_thresh(input logic [15:0] data, input int thresh);
    logic signed [16:0] d_ext;
    logic signed [16:0] t_ext;
    d_ext = $signed({data[15], data});
    t_ext = 17'(thresh);
    return (d_ext >= t_ext) || (d_ext <= -t_ext);
  endfunction

  function automatic logic l_over_thresh(input logic [15:0] data, input int thresh);
    return data >= 16'(thresh);
  endfunction

endpackage

// File: rtl/button_press_classifier.sv
// Synchronizes and debounces the raw pushbutton, then classifies each
// debounced press as a short or long event (one-cycle registered pulses).
module button_press_classifier
  import display_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic short_evt,
  output logic long_evt
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic              sync1_r;
  logic              sync2_r;
  logic              press_s;
  logic              db_press_r;
  logic [DB_W-1:0]   db_cnt_r;
  logic [HOLD_W-1:0] hold_r;
  logic [HOLD_W-1:0] hold_s;
  cls_state_e        state_r;
  cls_state_e        state_s;
  logic              short_s;
  logic              long_s;

  assign press_s = ~sync2_r;

  // Synchronizer and debounce; resets to "pressed" so a held button must be released first.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
      db_press_r <= 1'b1;
      db_cnt_r   <= '0;
    end else begin
      sync1_r <= btn_n;
      sync2_r <= sync1_r;
      if (press_s == db_press_r) begin
        db_cnt_r <= '0;
      end else if (db_cnt_r == DB_LAST) begin
        db_press_r <= press_s;
        db_cnt_r   <= '0;
      end else begin
        db_cnt_r <= db_cnt_r + DB_W'(1);
      end
    end
  end

  // Press classification; hold_r counts debounced-pressed cycles.
  always_comb begin
    state_s = state_r;
    hold_s  = hold_r;
    short_s = 1'b0;
    long_s  = 1'b0;
    case (state_r)
      CLS_IDLE: begin
        if (db_press_r) begin
          state_s = CLS_PRESSED;
          hold_s  = HOLD_W'(1);
        end else begin
          state_s = CLS_IDLE;
        end
      end
      CLS_PRESSED: begin
        if (!db_press_r) begin
          short_s = 1'b1;
          state_s = CLS_IDLE;
        end else if (hold_r == HOLD_LAST) begin
          long_s  = 1'b1;
          state_s = CLS_LONG_HELD;
        end else begin
          hold_s = hold_r + HOLD_W'(1);
        end
      end
      CLS_LONG_HELD, CLS_WAIT_RELEASE: begin
        if (!db_press_r) begin
          state_s = CLS_IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = CLS_WAIT_RELEASE;
    endcase
  end

  // State, hold counter and registered event pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= CLS_WAIT_RELEASE;
      hold_r    <= '0;
      short_evt <= 1'b0;
      long_evt  <= 1'b0;
    end else begin
      state_r   <= state_s;
      hold_r    <= hold_s;
      short_evt <= short_s;
      long_evt  <= long_s;
    end
  end

endmodule

// File: rtl/display_source_scheduler.sv
// Chooses which sensor drives the hex displays: auto dwell rotation with
// alarm preemption, or manual selection from the pushbutton.
module display_source_scheduler
  import display_ctrl_pkg::*;
#(
  parameter int DWELL_CYCLES      = DEF_DWELL_CYCLES,
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int G_THRESH          = DEF_G_THRESH,
  parameter int L_THRESH          = DEF_L_THRESH,
  parameter int ALARM_PERSIST     = DEF_ALARM_PERSIST
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_n,
  input  logic [15:0] gsensor_data,
  input  logic        gsensor_valid,
  input  logic [15:0] light_sensor_data,
  input  logic        light_valid,
  output logic        select,
  output logic [15:0] selected_data,
  output logic        mode_auto,
  output logic        alarm,
  output logic [1:0]  alarm_src
);

  localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int PC_W = $clog2(ALARM_PERSIST + 1);
  localparam logic [DW_W-1:0] DWELL_LAST  = DW_W'(DWELL_CYCLES - 1);
  localparam logic [PC_W-1:0] PERSIST_MAX = PC_W'(ALARM_PERSIST);

  logic            short_evt_s;
  logic            long_evt_s;
  logic [PC_W-1:0] g_cnt_r;
  logic [PC_W-1:0] g_cnt_s;
  logic [PC_W-1:0] l_cnt_r;
  logic [PC_W-1:0] l_cnt_s;
  logic [1:0]      alarm_src_s;
  logic [DW_W-1:0] dwell_r;
  logic [DW_W-1:0] dwell_s;
  logic            select_s;
  logic            mode_s;

  button_press_classifier #(
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
  ) u_button (
    .clk      (clk),
    .reset    (reset),
    .btn_n    (btn_n),
    .short_evt(short_evt_s),
    .long_evt (long_evt_s)
  );

  function automatic logic [PC_W-1:0] persist_next(input logic [PC_W-1:0] cnt,
                                                   input logic valid, input logic over);
    logic [PC_W-1:0] nxt;
    if (!valid) begin
      nxt = cnt;
    end else if (!over) begin
      nxt = '0;
    end else if (cnt == PERSIST_MAX) begin
      nxt = cnt;
    end else begin
      nxt = cnt + PC_W'(1);
    end
    return nxt;
  endfunction

  // Per-source alarm persistence; alarm_src reflects the post-strobe count.
  always_comb begin
    alarm_src_s              = 2'b00;
    g_cnt_s                  = persist_next(g_cnt_r, gsensor_valid,
                                            g_over_thresh(gsensor_data, G_THRESH));
    l_cnt_s                  = persist_next(l_cnt_r, light_valid,
                                            l_over_thresh(light_sensor_data, L_THRESH));
    alarm_src_s[ALARM_G_BIT] = (g_cnt_s == PERSIST_MAX);
    alarm_src_s[ALARM_L_BIT] = (l_cnt_s == PERSIST_MAX);
  end

  // Source selection: long press owns the cycle, then preemption, then button/dwell.
  always_comb begin
    mode_s   = mode_auto;
    select_s = select;
    dwell_s  = dwell_r;
    if (long_evt_s) begin
      mode_s  = ~mode_auto;
      dwell_s = '0;
    end else if (mode_auto) begin
      case (alarm_src)
        2'b01: begin
          select_s = SRC_GSENSOR;
          dwell_s  = '0;
        end
        2'b10: begin
          select_s = SRC_LIGHT;
          dwell_s  = '0;
        end
        2'b11: dwell_s = '0;
        default: begin
          if (short_evt_s || (dwell_r == DWELL_LAST)) begin
            select_s = ~select;
            dwell_s  = '0;
          end else begin
            dwell_s = dwell_r + DW_W'(1);
          end
        end
      endcase
    end else begin
      dwell_s = '0;
      if (short_evt_s) begin
        select_s = ~select;
      end else begin
        select_s = select;
      end
    end
  end

  // Output and state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      select        <= SRC_GSENSOR;
      selected_data <= 16'h0000;
      mode_auto     <= 1'b1;
      alarm         <= 1'b0;
      alarm_src     <= 2'b00;
      dwell_r       <= '0;
      g_cnt_r       <= '0;
      l_cnt_r       <= '0;
    end else begin
      select        <= select_s;
      selected_data <= (select == SRC_LIGHT) ? light_sensor_data : gsensor_data;
      mode_auto     <= mode_s;
      alarm         <= |alarm_src_s;
      alarm_src     <= alarm_src_s;
      dwell_r       <= dwell_s;
      g_cnt_r       <= g_cnt_s;
      l_cnt_r       <= l_cnt_s;
    end
  end

endmodule

// File: tb/tb_display_source_scheduler.sv
// Directed bench: event-time model of the scheduler checked every cycle,
// plus hand-computed checkpoints along the stimulus.
module tb_display_source_scheduler;

  localparam int DWELL = 10;
  localparam int DEB   = 4;
  localparam int LONG  = 20;
  localparam int PERS  = 3;
  localparam int GT    = 2;
  localparam int LT    = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_n;
  logic [15:0] gsensor_data;
  logic        gsensor_valid;
  logic [15:0] light_sensor_data;
  logic        light_valid;
  logic        select;
  logic [15:0] selected_data;
  logic        mode_auto;
  logic        alarm;
  logic [1:0]  alarm_src;

  int checks = 0;
  int fails  = 0;

  display_source_scheduler #(
    .DWELL_CYCLES(DWELL), .DEBOUNCE_CYCLES(DEB), .LONG_PRESS_CYCLES(LONG),
    .G_THRESH(GT), .L_THRESH(LT), .ALARM_PERSIST(PERS)
  ) dut (
    .clk(clk), .reset(reset), .btn_n(btn_n),
    .gsensor_data(gsensor_data), .gsensor_valid(gsensor_valid),
    .light_sensor_data(light_sensor_data), .light_valid(light_valid),
    .select(select), .selected_data(selected_data), .mode_auto(mode_auto),
    .alarm(alarm), .alarm_src(alarm_src)
  );

  always #5 clk = ~clk;

  // Model state: times are counted in clock edges since reset released.
  int          rel_cyc = 0;
  int          t_rot, t_p, short_at, long_at, g_run, l_run;
  bit          m_select, m_mode, m_alarm, m_db, armed, pressing, long_done;
  bit          started = 1'b0;
  logic [1:0]  m_src;
  logic [15:0] m_data;
  bit          raw_q[$];

  task automatic model_step();
    bit         old_sel;
    logic [1:0] old_src;
    bit         ev_s, ev_l, flip;
    int         gv, lv;
    started = 1'b1;
    if (reset) begin
      rel_cyc = 0; t_rot = 0; t_p = 0; short_at = -1; long_at = -1;
      g_run = 0; l_run = 0;
      m_select = 1'b0; m_mode = 1'b1; m_alarm = 1'b0; m_src = 2'b00; m_data = 16'h0000;
      m_db = 1'b1; armed = 1'b0; pressing = 1'b0; long_done = 1'b0;
      raw_q.delete();
      for (int i = 0; i < 6; i++) raw_q.push_back(1'b0);
    end else begin
      rel_cyc++;
      raw_q.push_front(btn_n);
      if (raw_q.size() > 6) void'(raw_q.pop_back());
      ev_s = (short_at == rel_cyc);
      ev_l = (long_at == rel_cyc);
      if (pressing && !long_done && m_db && (rel_cyc - t_p == LONG)) begin
        long_done = 1'b1;
        long_at   = rel_cyc + 1;
      end
      // Debounced level flips after DEB consecutive synchronized samples disagree with it.
      flip = 1'b1;
      for (int i = 2; i < 6; i++) if (raw_q[i] != m_db) flip = 1'b0;
      if (flip) begin
        m_db = !m_db;
        if (m_db) begin
          if (armed) begin
            pressing = 1'b1; t_p = rel_cyc; long_done = 1'b0;
          end
        end else if (!armed) begin
          armed = 1'b1;
        end else if (pressing) begin
          if (!long_done) short_at = rel_cyc + 2;
          pressing = 1'b0;
        end
      end
      old_sel = m_select;
      old_src = m_src;
      if (ev_l) begin
        m_mode = !m_mode; t_rot = rel_cyc;
      end else if (m_mode) begin
        if (old_src == 2'b11) begin
          t_rot = rel_cyc;
        end else if (old_src != 2'b00) begin
          m_select = old_src[1]; t_rot = rel_cyc;
        end else if (ev_s || (rel_cyc - t_rot == DWELL)) begin
          m_select = !m_select; t_rot = rel_cyc;
        end
      end else if (ev_s) begin
        m_select = !m_select;
      end
      m_data = old_sel ? light_sensor_data : gsensor_data;
      if (gsensor_valid) begin
        gv = $signed(gsensor_data);
        g_run = (gv >= GT || gv <= -GT) ? g_run + 1 : 0;
      end
      if (light_valid) begin
        lv = int'(light_sensor_data);
        l_run = (lv >= LT) ? l_run + 1 : 0;
      end
      m_src   = {l_run >= PERS, g_run >= PERS};
      m_alarm = (m_src != 2'b00);
    end
  endtask

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at t=%0t cyc=%0d: got %h expected %h", name, $time, rel_cyc, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        cmp("select", 16'(select), 16'(m_select));
        cmp("mode_auto", 16'(mode_auto), 16'(m_mode));
        cmp("alarm", 16'(alarm), 16'(m_alarm));
        cmp("alarm_src", 16'(alarm_src), 16'(m_src));
        cmp("selected_data", selected_data, m_data);
      end
    end
  end

  task automatic to_edge(input int n);
    for (int k = 0; k < 2000 && rel_cyc < n; k++) @(negedge clk);
    cmp("edge_reached", 16'(rel_cyc), 16'(n));
  endtask

  task automatic strobe(input int e, input bit gv, input logic [15:0] gd,
                        input bit lv, input logic [15:0] ld);
    to_edge(e - 1);
    gsensor_valid = gv;
    if (gv) gsensor_data = gd;
    light_valid = lv;
    if (lv) light_sensor_data = ld;
    to_edge(e);
    gsensor_valid = 1'b0;
    light_valid   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; btn_n = 1'b1;
    gsensor_data = 16'h0000; gsensor_valid = 1'b0;
    light_sensor_data = 16'h0000; light_valid = 1'b0;
    repeat (3) @(negedge clk);
    cmp("lit_rst_select", 16'(select), 16'd0);
    cmp("lit_rst_mode", 16'(mode_auto), 16'd1);
    cmp("lit_rst_src", 16'(alarm_src), 16'd0);
    reset = 1'b0;
    // Free-running rotation.
    to_edge(9);  cmp("lit_rot9", 16'(select), 16'd0);
    to_edge(10); cmp("lit_rot10", 16'(select), 16'd1);
    cmp("lit_rot_alarm", 16'(alarm), 16'd0);
    to_edge(20); cmp("lit_rot20", 16'(select), 16'd0);
    // Short press, then a glitch that must be filtered.
    to_edge(25); btn_n = 1'b0;
    to_edge(33); btn_n = 1'b1;
    to_edge(40); cmp("lit_short40", 16'(select), 16'd0);
    to_edge(41); cmp("lit_short41", 16'(select), 16'd1);
    to_edge(50); cmp("lit_short50", 16'(select), 16'd1);
    to_edge(51); cmp("lit_short51", 16'(select), 16'd0);
    to_edge(55); btn_n = 1'b0;
    to_edge(57); btn_n = 1'b1;
    to_edge(60); cmp("lit_glitch60", 16'(select), 16'd0);
    to_edge(61); cmp("lit_glitch61", 16'(select), 16'd1);
    // Long press into manual mode.
    to_edge(75);  btn_n = 1'b0;
    to_edge(101); cmp("lit_long101_mode", 16'(mode_auto), 16'd1);
    to_edge(102); cmp("lit_long102_mode", 16'(mode_auto), 16'd0);
    cmp("lit_long102_sel", 16'(select), 16'd1);
    to_edge(105); btn_n = 1'b1;
    to_edge(160); cmp("lit_manual_sel", 16'(select), 16'd1);
    // Long press back into auto.
    btn_n = 1'b0;
    to_edge(187); cmp("lit_auto187", 16'(mode_auto), 16'd1);
    to_edge(190); btn_n = 1'b1;
    to_edge(197); cmp("lit_auto197", 16'(select), 16'd0);
    // Light alarm preemption.
    strobe(200, 1'b0, 16'h0000, 1'b1, 16'd7);
    strobe(202, 1'b0, 16'h0000, 1'b1, 16'd7);
    to_edge(203); cmp("lit_alarm203", 16'(alarm), 16'd0);
    strobe(204, 1'b0, 16'h0000, 1'b1, 16'd7);
    cmp("lit_src204", 16'(alarm_src), 16'd2);
    cmp("lit_alarm204", 16'(alarm), 16'd1);
    to_edge(205); cmp("lit_force205", 16'(select), 16'd1);
    to_edge(206); cmp("lit_data206", selected_data, 16'd7);
    to_edge(230); cmp("lit_hold230", 16'(select), 16'd1);
    strobe(231, 1'b0, 16'h0000, 1'b1, 16'd3);
    to_edge(240); cmp("lit_resume240", 16'(select), 16'd1);
    to_edge(241); cmp("lit_resume241", 16'(select), 16'd0);
    // Both sources alarming, then gsensor drops out.
    strobe(245, 1'b1, 16'hFFFE, 1'b1, 16'd7);
    strobe(247, 1'b1, 16'hFFFE, 1'b1, 16'd7);
    strobe(249, 1'b1, 16'hFFFE, 1'b1, 16'd7);
    cmp("lit_src249", 16'(alarm_src), 16'd3);
    to_edge(270); cmp("lit_frozen270", 16'(select), 16'd0);
    strobe(272, 1'b1, 16'hFFFF, 1'b0, 16'h0000);
    cmp("lit_src272", 16'(alarm_src), 16'd2);
    to_edge(273); cmp("lit_force273", 16'(select), 16'd1);
    strobe(280, 1'b0, 16'h0000, 1'b1, 16'd0);
    // Reset in the middle of a long press.
    to_edge(285); btn_n = 1'b0;
    to_edge(300); reset = 1'b1;
    repeat (2) @(negedge clk);
    cmp("lit_mid_rst_sel", 16'(select), 16'd0);
    cmp("lit_mid_rst_data", selected_data, 16'd0);
    cmp("lit_mid_rst_mode", 16'(mode_auto), 16'd1);
    cmp("lit_mid_rst_alarm", 16'(alarm), 16'd0);
    reset = 1'b0;
    to_edge(40); cmp("lit_held_mode", 16'(mode_auto), 16'd1);
    cmp("lit_held_sel", 16'(select), 16'd0);
    btn_n = 1'b1;
    to_edge(49); cmp("lit_release49", 16'(select), 16'd0);
    to_edge(55); btn_n = 1'b0;
    to_edge(63); btn_n = 1'b1;
    to_edge(70); cmp("lit_repress70", 16'(select), 16'd1);
    to_edge(71); cmp("lit_repress71", 16'(select), 16'd0);
    to_edge(80);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
